// File: rtl/dadda_mul_pkg.sv
// Shared widths, id-width helper and the operand-stage payload for the Dadda multiplier arbiter.
// Pure declarations: no latency, no backpressure.
package dadda_mul_pkg;

    localparam int OP_W     = 16;
    localparam int RES_W    = 32;
    localparam int ID_MAX_W = 4;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // The id field is sized for the largest supported requester count (16).
    typedef struct packed {
        logic [OP_W-1:0]     a;
        logic [OP_W-1:0]     b;
        logic [ID_MAX_W-1:0] id;
    } s1_payload_t;

endpackage

// File: rtl/dadda_mul_16x16.sv
// Combinational unsigned 16x16 Dadda multiplier (13/9/6/4/3/2 reduction, final two-row add).
// Zero latency, no handshake.
module dadda_mul_16x16
    import dadda_mul_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [RES_W-1:0] p
);

    localparam int NCOL   = 2 * OP_W;
    localparam int NSTAGE = 6;

    function automatic int stage_height(input int s);
        int d;
        case (s)
            0:       d = 13;
            1:       d = 9;
            2:       d = 6;
            3:       d = 4;
            4:       d = 3;
            default: d = 2;
        endcase
        return d;
    endfunction

    function automatic logic [RES_W-1:0] dadda_reduce(input logic [OP_W-1:0] x,
                                                      input logic [OP_W-1:0] y);
        logic [OP_W-1:0]  cur [NCOL];
        logic [OP_W-1:0]  nxt [NCOL];
        int               h   [NCOL];
        int               nh  [NCOL];
        logic [OP_W-1:0]  t;
        logic [1:0]       fa;
        logic [RES_W-1:0] row0;
        logic [RES_W-1:0] row1;
        int               d;
        int               pos;
        int               eh;

        for (int c = 0; c < NCOL; c++) begin
            cur[c] = '0;
            h[c]   = 0;
        end
        for (int i = 0; i < OP_W; i++) begin
            for (int j = 0; j < OP_W; j++) begin
                cur[i+j] = cur[i+j] | (OP_W'(x[i] & y[j]) << h[i+j]);
                h[i+j]   = h[i+j] + 1;
            end
        end

        for (int s = 0; s < NSTAGE; s++) begin
            d = stage_height(s);
            for (int c = 0; c < NCOL; c++) begin
                nxt[c] = '0;
                nh[c]  = 0;
            end
            // Column height counts carries already pushed in from the column below.
            for (int c = 0; c < NCOL; c++) begin
                pos = 0;
                eh  = h[c] + nh[c];
                for (int k = 0; k < 10; k++) begin
                    if (eh > d) begin
                        t = cur[c] >> pos;
                        if (eh - d >= 2) begin
                            fa  = 2'(t[0]) + 2'(t[1]) + 2'(t[2]);
                            pos = pos + 3;
                            eh  = eh - 2;
                        end else begin
                            fa  = 2'(t[0]) + 2'(t[1]);
                            pos = pos + 2;
                            eh  = eh - 1;
                        end
                        nxt[c] = nxt[c] | (OP_W'(fa[0]) << nh[c]);
                        nh[c]  = nh[c] + 1;
                        if (c < NCOL - 1) begin
                            nxt[c+1] = nxt[c+1] | (OP_W'(fa[1]) << nh[c+1]);
                            nh[c+1]  = nh[c+1] + 1;
                        end
                    end
                end
                t      = cur[c] >> pos;
                nxt[c] = nxt[c] | (t << nh[c]);
                nh[c]  = nh[c] + h[c] - pos;
            end
            cur = nxt;
            h   = nh;
        end

        row0 = '0;
        row1 = '0;
        for (int c = 0; c < NCOL; c++) begin
            row0 = row0 | (RES_W'(cur[c][0]) << c);
            row1 = row1 | (RES_W'(cur[c][1]) << c);
        end
        return row0 + row1;
    endfunction

    assign p = dadda_reduce(a, b);

endmodule

// File: rtl/dadda_mul_arbiter_rr_arbiter.sv
// Round-robin request picker: scans req from ptr upward, wrapping; first set bit wins.
// Combinational, zero latency; the caller applies any stall to the grant.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/dadda_mul_arbiter.sv
// Shares one Dadda multiplier among NREQ requesters with round-robin grant; operand stage S1, result stage S2.
// Fire-to-response two edges, one product per cycle; a stalled S2 with full S1 drops all req_ready.
module dadda_mul_arbiter
    import dadda_mul_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = id_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RES_W-1:0]     rsp_data,
    output logic [IDW-1:0]       rsp_id
);

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   next_ptr;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_any;
    logic             s1_valid;
    logic             s2_valid;
    logic             s1_en;
    logic             s2_en;
    logic             fire;
    s1_payload_t      s1_q;
    s1_payload_t      s1_d;
    logic [RES_W-1:0] prod;
    logic [RES_W-1:0] s2_data;
    logic [IDW-1:0]   s2_id;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    assign s2_en = !s2_valid || rsp_ready;
    assign s1_en = !s1_valid || s2_en;
    // Gating with rst keeps req_ready low for the whole reset window.
    assign fire      = s1_en && gnt_any && !rst;
    assign req_ready = fire ? gnt : '0;
    assign next_ptr  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        s1_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                s1_d.a = req_a[i*OP_W +: OP_W];
                s1_d.b = req_b[i*OP_W +: OP_W];
            end
        end
        s1_d.id = ID_MAX_W'(gnt_idx);
    end

    dadda_mul_16x16 u_mul (
        .a (s1_q.a),
        .b (s1_q.b),
        .p (prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_id    <= '0;
        end else begin
            if (fire) begin
                s1_q     <= s1_d;
                s1_valid <= 1'b1;
                rr_ptr   <= next_ptr;
            end else if (s2_en) begin
                s1_valid <= 1'b0;
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                s2_data  <= prod;
                s2_id    <= s1_q.id[IDW-1:0];
            end
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_data  = s2_data;
    assign rsp_id    = s2_id;

endmodule
